// File: rtl/axi_w_arbiter_fsm_if.sv
// Bundle of the AW/W/B handshake signals seen by the write-path arbiter,
// plus the arbiter's state/grant/beat-count outputs.
// Modports: slave = arbiter side, master = driving side.
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 8
`endif
`ifndef WRITESTATE_IDLE
`define WRITESTATE_IDLE 2'b00
`endif
`ifndef WRITESTATE_WTRANS
`define WRITESTATE_WTRANS 2'b01
`endif
`ifndef WRITESTATE_BTRANS
`define WRITESTATE_BTRANS 2'b10
`endif

interface axi_w_arbiter_fsm_if #(
    parameter int unsigned MasterCount = 2,
    parameter int unsigned CntBits     = 9
);
    logic [MasterCount-1:0]                     AWVALID_MS;
    logic [MasterCount-1:0][`AXI_LEN_BITS-1:0]  AWLEN_MS;
    logic                                       AWREADY;
    logic                                       WVALID;
    logic                                       WREADY;
    logic                                       WLAST;
    logic                                       BVALID;
    logic                                       BREADY;
    logic [1:0]                                 state;
    logic [MasterCount-1:0]                     sel_Master;
    logic [CntBits-1:0]                         wbeat_cnt;
    logic                                       len_err;

    modport slave (
        input  AWVALID_MS, AWLEN_MS, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY,
        output state, sel_Master, wbeat_cnt, len_err
    );

    modport master (
        output AWVALID_MS, AWLEN_MS, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY,
        input  state, sel_Master, wbeat_cnt, len_err
    );
endinterface

// File: rtl/axi_w_arbiter_fsm.sv
// Write-path arbiter: grants one master per write transaction (AW, W, B),
// drives the W-mux state/select, counts W beats and flags AWLEN mismatches.
// Optional macro AXI_WARB_ROUND_ROBIN_EN: round-robin arbitration instead of
// fixed priority (index 0 highest).
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 8
`endif
`ifndef WRITESTATE_IDLE
`define WRITESTATE_IDLE 2'b00
`endif
`ifndef WRITESTATE_WTRANS
`define WRITESTATE_WTRANS 2'b01
`endif
`ifndef WRITESTATE_BTRANS
`define WRITESTATE_BTRANS 2'b10
`endif

module axi_w_arbiter_fsm #(
    parameter int unsigned MasterCount = 2,
    parameter int unsigned CntBits     = 9
) (
    input logic                ACLK,
    input logic                ARESETn,
    axi_w_arbiter_fsm_if.slave bus
);
    localparam int unsigned IdxBits = (MasterCount > 1) ? $clog2(MasterCount) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = `WRITESTATE_IDLE,
        ST_WTRANS = `WRITESTATE_WTRANS,
        ST_BTRANS = `WRITESTATE_BTRANS
    } state_e;

    state_e                 state_q, state_d;
    logic [MasterCount-1:0] lock_q, lock_d;
    logic [CntBits-1:0]     exp_q, exp_d;
    logic [CntBits-1:0]     wbeat_cnt_q, wbeat_cnt_d;
    logic                   len_err_q, len_err_d;
`ifdef AXI_WARB_ROUND_ROBIN_EN
    logic [IdxBits-1:0]     ptr_q, ptr_d;
    logic [IdxBits-1:0]     lock_idx_q, lock_idx_d;
`endif

    logic [MasterCount-1:0] grant;
    logic [IdxBits-1:0]     win_idx;
    logic                   req_any;
    int unsigned            cand;
    logic                   w_hs, b_hs, aw_hs;
    logic [CntBits-1:0]     cnt_inc;
    logic [CntBits-1:0]     aw_exp;
    logic [MasterCount-1:0] sel;

    // Arbitration: first requester found scanning from the start index.
    always_comb begin
        grant   = '0;
        win_idx = '0;
        req_any = 1'b0;
        cand    = 0;
        for (int unsigned k = 0; k < MasterCount; k++) begin
`ifdef AXI_WARB_ROUND_ROBIN_EN
            cand = int'(ptr_q) + k;
            if (cand >= MasterCount) cand = cand - MasterCount;
`else
            cand = k;
`endif
            if (!req_any && bus.AWVALID_MS[IdxBits'(cand)]) begin
                req_any                = 1'b1;
                grant[IdxBits'(cand)]  = 1'b1;
                win_idx                = IdxBits'(cand);
            end
        end
    end

    // Next-state, lock, beat counter and length-check logic.
    always_comb begin
        w_hs    = bus.WVALID & bus.WREADY;
        b_hs    = bus.BVALID & bus.BREADY;
        aw_hs   = req_any & bus.AWREADY;
        cnt_inc = (&wbeat_cnt_q) ? wbeat_cnt_q : wbeat_cnt_q + CntBits'(1);
        aw_exp  = CntBits'(bus.AWLEN_MS[win_idx]) + CntBits'(1);

        state_d     = state_q;
        lock_d      = lock_q;
        exp_d       = exp_q;
        wbeat_cnt_d = wbeat_cnt_q;
        len_err_d   = len_err_q;
`ifdef AXI_WARB_ROUND_ROBIN_EN
        ptr_d       = ptr_q;
        lock_idx_d  = lock_idx_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (aw_hs) begin
                    lock_d      = grant;
                    exp_d       = aw_exp;
                    len_err_d   = 1'b0;
                    wbeat_cnt_d = '0;
                    state_d     = ST_WTRANS;
`ifdef AXI_WARB_ROUND_ROBIN_EN
                    lock_idx_d  = win_idx;
`endif
                    // A beat accepted alongside the AW belongs to this burst.
                    if (w_hs) begin
                        wbeat_cnt_d = CntBits'(1);
                        if (bus.WLAST) begin
                            len_err_d = (aw_exp != CntBits'(1));
                            state_d   = ST_BTRANS;
                        end else if (aw_exp == CntBits'(1)) begin
                            len_err_d = 1'b1;
                        end
                    end
                end
            end
            ST_WTRANS: begin
                if (w_hs) begin
                    wbeat_cnt_d = cnt_inc;
                    if (bus.WLAST) begin
                        if (cnt_inc != exp_q) len_err_d = 1'b1;
                        state_d = ST_BTRANS;
                    end else if (cnt_inc == exp_q) begin
                        len_err_d = 1'b1;
                    end
                end
            end
            ST_BTRANS: begin
                if (b_hs) begin
                    state_d = ST_IDLE;
                    lock_d  = '0;
`ifdef AXI_WARB_ROUND_ROBIN_EN
                    if (int'(lock_idx_q) + 1 >= MasterCount) ptr_d = '0;
                    else ptr_d = lock_idx_q + IdxBits'(1);
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
                lock_d  = '0;
            end
        endcase
    end

    // State and bookkeeping registers.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q     <= ST_IDLE;
            lock_q      <= '0;
            exp_q       <= '0;
            wbeat_cnt_q <= '0;
            len_err_q   <= 1'b0;
`ifdef AXI_WARB_ROUND_ROBIN_EN
            ptr_q       <= '0;
            lock_idx_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            lock_q      <= lock_d;
            exp_q       <= exp_d;
            wbeat_cnt_q <= wbeat_cnt_d;
            len_err_q   <= len_err_d;
`ifdef AXI_WARB_ROUND_ROBIN_EN
            ptr_q       <= ptr_d;
            lock_idx_q  <= lock_idx_d;
`endif
        end
    end

    // Grant select: live arbitration in IDLE, locked master otherwise.
    always_comb begin
        case (state_q)
            ST_IDLE:              sel = grant;
            ST_WTRANS, ST_BTRANS: sel = lock_q;
            default:              sel = '0;
        endcase
    end

    assign bus.state      = state_q;
    assign bus.sel_Master = sel;
    assign bus.wbeat_cnt  = wbeat_cnt_q;
    assign bus.len_err    = len_err_q;
endmodule

// File: tb/tb_axi_w_arbiter_fsm.sv
// Scoreboard bench for axi_w_arbiter_fsm: the driver pushes each
// transaction's expected grant/beat count/length flag, a monitor pops and
// compares at every B handshake. Define AXI_WARB_ROUND_ROBIN_EN for both
// the design and this bench to exercise round-robin arbitration.
module tb_axi_w_arbiter_fsm;
    localparam int unsigned MC = 2;
    localparam int unsigned CB = 9;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    axi_w_arbiter_fsm_if #(.MasterCount(MC), .CntBits(CB)) bus ();
    axi_w_arbiter_fsm #(.MasterCount(MC), .CntBits(CB)) dut (
        .ACLK   (clk),
        .ARESETn(rst_n),
        .bus    (bus)
    );

    typedef struct {
        logic [MC-1:0] sel;
        int unsigned   cnt;
        logic          err;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad = 0;
    int   rr_ptr = 0;
    logic last_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference arbitration: first requester from the start index, wrapping.
    function automatic int pick(input logic [MC-1:0] req);
        int            base;
        int            idx;
        logic [MC-1:0] v;
        base = 0;
`ifdef AXI_WARB_ROUND_ROBIN_EN
        base = rr_ptr;
`endif
        for (int k = 0; k < MC; k++) begin
            idx = (base + k) % MC;
            v = req >> idx;
            if (v[0]) return idx;
        end
        return 0;
    endfunction

    task automatic do_txn(input logic [MC-1:0] req, input int awlen, input int beats,
                          input int aw_wait, input int b_wait, input bit same);
        int            win;
        logic [MC-1:0] gexp;
        exp_t          e;
        int            sent;
        int            guard;
        win  = pick(req);
        gexp = MC'(1) << win;
        e.sel = gexp;
        e.cnt = beats;
        e.err = (beats != awlen + 1);
        sb_q.push_back(e);

        tick();
        for (int m = 0; m < MC; m++)
            bus.AWLEN_MS[m] = (m == win) ? 8'(awlen) : 8'($urandom_range(0, 255));
        bus.AWVALID_MS = req;
        bus.AWREADY    = 1'b0;
        for (int i = 0; i < aw_wait; i++) begin
            #2;
            chk("aw_wait_state", 32'(bus.state), 32'd0);
            chk("aw_wait_sel", 32'(bus.sel_Master), 32'(gexp));
            tick();
        end
        bus.AWREADY = 1'b1;
        if (same) begin
            bus.WVALID = 1'b1;
            bus.WREADY = 1'b1;
            bus.WLAST  = 1'b1;
        end
        #2;
        chk("aw_grant_sel", 32'(bus.sel_Master), 32'(gexp));
        chk("err_hold_idle", 32'(bus.len_err), 32'(last_err));
        tick();
        bus.AWVALID_MS = '0;
        bus.AWREADY    = 1'b0;
        bus.WVALID     = 1'b0;
        bus.WREADY     = 1'b0;
        bus.WLAST      = 1'b0;
        #2;
        chk("post_aw_state", 32'(bus.state), same ? 32'd2 : 32'd1);
        chk("post_aw_sel", 32'(bus.sel_Master), 32'(gexp));
        if (!same) begin
            chk("post_aw_len_err", 32'(bus.len_err), 32'd0);
            chk("post_aw_cnt", 32'(bus.wbeat_cnt), 32'd0);
            sent  = 0;
            guard = 0;
            while (sent < beats) begin
                bus.WVALID = (guard >= 8) || ($urandom_range(0, 3) != 0);
                bus.WREADY = (guard >= 8) || ($urandom_range(0, 3) != 0);
                bus.WLAST  = bus.WVALID && (sent == beats - 1);
                if (bus.WVALID && bus.WREADY) begin
                    sent++;
                    guard = 0;
                end else begin
                    guard++;
                end
                tick();
            end
            bus.WVALID = 1'b0;
            bus.WREADY = 1'b0;
            bus.WLAST  = 1'b0;
            #2;
            chk("pre_b_state", 32'(bus.state), 32'd2);
        end
        for (int i = 0; i < b_wait; i++) begin
            bus.BREADY = 1'($urandom_range(0, 1));
            tick();
        end
        bus.BVALID = 1'b1;
        bus.BREADY = 1'b1;
        tick();
        bus.BVALID = 1'b0;
        bus.BREADY = 1'b0;
        #2;
        chk("post_b_state", 32'(bus.state), 32'd0);
        chk("post_b_sel_none", 32'(bus.sel_Master), 32'd0);
        chk("post_b_err_hold", 32'(bus.len_err), 32'(e.err));
        last_err = e.err;
        rr_ptr   = (win + 1) % MC;
    endtask

    // Monitor: compare the locked grant and beat bookkeeping at each B handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && bus.BVALID && bus.BREADY && bus.state == 2'b10) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_underflow actual=B_handshake required=none at %0t", $time);
            end else begin
                e = sb_q.pop_front();
                chk("sb_sel", 32'(bus.sel_Master), 32'(e.sel));
                chk("sb_cnt", 32'(bus.wbeat_cnt), e.cnt);
                chk("sb_len_err", 32'(bus.len_err), 32'(e.err));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int awlen;
        int beats;
        logic [MC-1:0] req;
        rst_n          = 1'b0;
        bus.AWVALID_MS = '0;
        bus.AWLEN_MS   = '0;
        bus.AWREADY    = 1'b0;
        bus.WVALID     = 1'b0;
        bus.WREADY     = 1'b0;
        bus.WLAST      = 1'b0;
        bus.BVALID     = 1'b0;
        bus.BREADY     = 1'b0;
        tick();
        tick();
        chk("rst_state", 32'(bus.state), 32'd0);
        chk("rst_sel", 32'(bus.sel_Master), 32'd0);
        chk("rst_cnt", 32'(bus.wbeat_cnt), 32'd0);
        chk("rst_err", 32'(bus.len_err), 32'd0);
        rst_n = 1'b1;

        do_txn(2'b01, 3, 4, 0, 2, 1'b0);   // basic 4-beat burst
        do_txn(2'b01, 0, 1, 0, 1, 1'b1);   // AW and single WLAST beat together
        do_txn(2'b01, 3, 2, 0, 0, 1'b0);   // short burst, len_err held in IDLE
        do_txn(2'b01, 1, 2, 1, 0, 1'b0);   // len_err cleared by next AW

        // Reset during WTRANS after 2 of 4 beats.
        tick();
        bus.AWVALID_MS  = 2'b01;
        bus.AWLEN_MS[0] = 8'd3;
        bus.AWREADY     = 1'b1;
        tick();
        bus.AWVALID_MS = '0;
        bus.AWREADY    = 1'b0;
        bus.WVALID     = 1'b1;
        bus.WREADY     = 1'b1;
        tick();
        tick();
        bus.WVALID = 1'b0;
        bus.WREADY = 1'b0;
        #2;
        chk("mid_state", 32'(bus.state), 32'd1);
        chk("mid_cnt", 32'(bus.wbeat_cnt), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("arst_state", 32'(bus.state), 32'd0);
        chk("arst_sel", 32'(bus.sel_Master), 32'd0);
        chk("arst_cnt", 32'(bus.wbeat_cnt), 32'd0);
        chk("arst_err", 32'(bus.len_err), 32'd0);
        tick();
        rst_n    = 1'b1;
        rr_ptr   = 0;
        last_err = 1'b0;
        do_txn(2'b10, 2, 3, 0, 1, 1'b0);

        // Contention: both masters request for two transactions.
        do_txn(2'b11, 1, 2, 0, 0, 1'b0);
        do_txn(2'b11, 1, 2, 0, 0, 1'b0);

        // AWREADY held low five cycles.
        do_txn(2'b10, 0, 1, 5, 0, 1'b0);

        // Longest burst.
        do_txn(2'b01, 255, 256, 0, 0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            req = MC'($urandom_range(1, (1 << MC) - 1));
            awlen = $urandom_range(0, 6);
            if ($urandom_range(0, 4) == 0) begin
                do_txn(req, awlen, 1, $urandom_range(0, 2), $urandom_range(0, 2), 1'b1);
            end else begin
                beats = awlen + 1 + $urandom_range(0, 2) - 1;
                if (beats < 1) beats = 1;
                do_txn(req, awlen, beats, $urandom_range(0, 2), $urandom_range(0, 3), 1'b0);
            end
        end

        tick();
        tick();
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axi_w_arbiter_fsm.md
Name: axi_w_arbiter_fsm

Overview:
- Write-path arbitration controller for the AXI interconnect.
- Sits directly upstream of the W-channel master-to-slave mux and drives its `state` and `sel_Master` inputs.
- Arbitrates AW requests from all masters and locks one master for the whole write transaction (AW, W burst, B).
- Tracks W beats against AWLEN and flags length mismatches.

Parameters:
- MasterCount, 2, number of masters; width of all per-master vectors.
- CntBits, 9, width of the W beat counter; must be at least AXI_LEN_BITS+1.

Ports:
- ACLK  input  1  AXI clock
- ARESETn  input  1  asynchronous active-low reset
- AWVALID_MS  input  MasterCount  AWVALID from each master
- AWLEN_MS  input  MasterCount x `AXI_LEN_BITS  AWLEN from each master
- AWREADY  input  1  AWREADY from the addressed slave (post-decode)
- WVALID  input  1  muxed WVALID (W mux output)
- WREADY  input  1  WREADY from the addressed slave
- WLAST  input  1  muxed WLAST
- BVALID  input  1  BVALID from the addressed slave
- BREADY  input  1  BREADY from the locked master
- state  output  2  write state, encoded with `WRITESTATE_IDLE/_WTRANS/_BTRANS
- sel_Master  output  MasterCount  one-hot grant, all-zero when no grant
- wbeat_cnt  output  CntBits  accepted W beats in the current transaction
- len_err  output  1  sticky length-mismatch flag, cleared on the next AW handshake

Behaviour:
- Reset (async, ARESETn low):
  - state=`WRITESTATE_IDLE, sel_Master=0, wbeat_cnt=0, len_err=0.
  - Lock register and round-robin pointer cleared; pointer=0.
  - Reset mid-transaction abandons the transaction with no residual grant.
- IDLE:
  - sel_Master is combinational from arbitration over AWVALID_MS, so AW and early W pass through in the same cycle.
  - No AWVALID: sel_Master=0.
  - Winner is fixed priority, lowest index highest, unless the optional feature is enabled.
- AW handshake (IDLE & AWVALID_MS[winner] & AWREADY):
  - Register winner into the lock.
  - Latch expected beats = AWLEN_MS[winner]+1, computed at CntBits width so AWLEN max does not overflow.
  - Clear len_err and wbeat_cnt.
  - Next state is WTRANS.
  - If the same cycle also has WVALID&WREADY&WLAST: count that beat, run the length check, go straight to BTRANS.
- W before AW: a W beat accepted in IDLE before the AW handshake is ignored by the counter. Masters must not issue W ahead of AW.
- WTRANS:
  - sel_Master = lock register (registered, glitch-free).
  - Each WVALID&WREADY increments wbeat_cnt.
  - On a beat with WLAST: if the count including this beat ≠ expected, set len_err. Go to BTRANS.
  - If the count reaches expected without WLAST: set len_err and stay in WTRANS until WLAST.
  - Counter saturates at all-ones.
- BTRANS:
  - sel_Master = lock register.
  - On BVALID&BREADY: go to IDLE, release the lock (sel_Master becomes combinational arbitration the next cycle), update the round-robin pointer.
  - The next AW may be granted no earlier than the cycle after the B handshake.
- Unused state encoding: next state IDLE, sel_Master=0.
- Simultaneous requests: exactly one bit of sel_Master is high; never multi-hot.
- Latency: AW grant is 0 cycles from AWVALID in IDLE. State updates 1 cycle after each handshake.
- len_err holds through IDLE until the next AW handshake.

Optional Feature:
- Macro: AXI_WARB_ROUND_ROBIN_EN.
- Defined:
  - Round-robin arbitration; the pointer is stored as the index after the last granted master, modulo MasterCount.
  - Search starts at the pointer and wraps around.
  - Pointer updates only on the B handshake.
- Undefined:
  - Fixed priority, index 0 highest.
  - No pointer register is synthesized.

Test Plan:
- Single master 0, AWLEN=3, AWREADY immediate, 4 W beats with WLAST on the 4th, B after 2 cycles:
  - state 00→01→10→00.
  - sel_Master=01 throughout.
  - wbeat_cnt=4, len_err=0.
- AW handshake and a single beat (AWLEN=0, WLAST=1) in the same cycle → state IDLE→BTRANS directly, wbeat_cnt=1.
- AWLEN=3 but WLAST on beat 2 → len_err=1 after beat 2; it holds through IDLE and clears on the next AW handshake.
- Both AWVALID_MS=11 continuously for two transactions:
  - Feature off: sel_Master=01 both times.
  - Feature on: 01, then 10.
- Assert ARESETn low during WTRANS after 2 of 4 beats → immediately state=00, sel_Master=00, wbeat_cnt=0. A new AW from master 1 is granted after reset release.
- AWREADY held low 5 cycles with AWVALID_MS=10 → state stays 00, sel_Master=10 stable; WTRANS entered the cycle after AWREADY rises.
